mc_datapath: RTL and testbench
==============================

Name: mc_datapath

Overview:
- Multicycle MIPS datapath. Sits directly downstream of the `Control` FSM, executes its per-cycle control word, and returns `op` to it.
- Holds the architectural and inter-stage registers: PC, IR, MDR, A, B, ALUOut.
- Contains the register file, the ALU with its ALUop/funct decode, and all datapath muxes.
- Drives a single unified instruction/data memory port.

Parameters:
- WIDTH, 32, datapath and memory word width in bits.
- PC_RESET, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk input 1 system clock, rising edge.
- reset input 1 asynchronous, active-high reset.
- PCSrc input 2 PC next-value select.
- ALUSrcA input 1 ALU operand A select.
- ALUSrcB input 2 ALU operand B select.
- IorD input 1 memory address select.
- MemtoReg input 1 register-file write-data select.
- IRWrite input 1 IR load enable.
- RegWrite input 1 register-file write enable.
- MemWrite input 1 memory write request.
- RegDst input 1 register-file destination select.
- PCwritecond input 1 PC write, qualified by ALU zero.
- PCWrite input 1 unconditional PC write.
- ALUop input 2 ALU operation class.
- op output 6 IR[31:26], fed back to Control.
- mem_addr output WIDTH memory byte address.
- mem_wdata output WIDTH memory write data.
- mem_we output 1 memory write strobe.
- mem_rdata input WIDTH memory read data; combinational (asynchronous) read of mem_addr.

Behaviour:
- Reset (async, active-high): PC=PC_RESET; IR, MDR, A, B, ALUOut = 0; all 32 register-file entries = 0. Registers hold these values while reset is high. The first rising edge after deassertion is the IF cycle at PC_RESET. Reset asserted mid-instruction aborts it; no partial register-file or PC update survives.
- Outputs during reset:
  - op = 0.
  - mem_addr = PC_RESET, because Control drives IorD=0 in reset.
  - mem_we = MemWrite (0 in reset).
- IR: loads mem_rdata at the edge when IRWrite=1; otherwise holds.
- MDR, A, B, ALUOut: load every edge, unconditionally.
  - MDR <= mem_rdata.
  - A <= RF[IR[25:21]].
  - B <= RF[IR[20:16]].
  - ALUOut <= alu_result.
- Register file: two asynchronous read ports, one synchronous write port.
  - Write address: RegDst=1 selects IR[15:11]; otherwise IR[20:16].
  - Write data: MemtoReg=1 selects MDR; otherwise ALUOut.
  - Writes to register 0 are ignored; reads of register 0 return 0.
  - A read of the register being written in the same cycle returns the old value; A/B capture the new value one cycle later.
- ALU operand A: ALUSrcA=0 selects PC; 1 selects A.
- ALU operand B:
  - 00 = B.
  - 01 = constant 4.
  - 10 = sign-extended IR[15:0].
  - 11 = sign-extended IR[15:0] shifted left by 2.
- ALU operation:
  - ALUop=00: add.
  - ALUop=01: subtract.
  - ALUop=10: decode funct IR[5:0]:
    - 100000 = add.
    - 100010 = sub.
    - 100100 = and.
    - 100101 = or.
    - 101010 = slt (signed; result is 1 or 0).
    - Any other funct = add.
  - ALUop=11: add.
  - Arithmetic wraps modulo 2^WIDTH; no overflow trap.
- zero flag: combinational, alu_result == 0.
- PC next value:
  - PCSrc=00: alu_result.
  - PCSrc=01: ALUOut.
  - PCSrc=10: {PC[31:28], IR[25:0], 2'b00}.
  - PCSrc=11: current PC.
- PC write: PC loads at the edge when PCWrite=1, or when PCwritecond=1 and zero=1. If both PCWrite and PCwritecond are asserted, PCWrite wins and the write is unconditional.
- Memory port:
  - mem_addr: IorD=1 selects ALUOut; otherwise PC.
  - mem_wdata = B.
  - mem_we = MemWrite, passed through combinationally.
- Per-instruction latency, set entirely by Control: lw 5 cycles; R-type, sw, addi 4; beq, j 3.

Decomposition:
- Shared package `mips_defs`:
  - Opcode constants: R_type, addi, sw, lw, beq, j.
  - funct constants: add, sub, and, or, slt.
  - ALUop encodings.
  - PCSrc and ALUSrcB encodings.
  - Internal ALU-operation enum.
  - Control reuses the same opcode constants.
- One sub-module, `reg_file`: 32x WIDTH, 2 async read ports, 1 sync write port, async clear, register 0 hardwired to 0.
- ALU and funct decode stay inline in mc_datapath.

Test Plan:
- Reset release with PC_RESET=0, memory word 0 = 0x20080005 (addi $8,$0,5): after IF, PC=4 and op=6'b001000; after the 4-cycle sequence, RF[8]=5.
- R-type: $8=5, $9=7, instruction add $10,$8,$9 (0x01095020) -> RF[10]=12. Then slt $11,$9,$8 -> RF[11]=0; with $9=-1, slt -> RF[11]=1.
- sw then lw: sw $10,8($0) -> mem_we=1 for exactly one cycle, mem_addr=8, mem_wdata=12. Then lw $12,8($0) -> RF[12]=12 after the writeback cycle.
- beq both ways:
  - beq $8,$8,+3 at PC=0x10 -> PC=0x20.
  - beq $8,$9,+3 at PC=0x10 -> PC=0x14 (the PC+4 value from IF is kept).
- j 0x0000040 at PC=0x30000000 -> PC=0x30000100.
- Writes to $0 are discarded (addi $0,$0,9 -> RF[0] reads 0). Asserting reset in the middle of an lw (mem_access cycle) leaves the destination register unchanged and restarts fetch at PC_RESET.

Source files
------------

// File: rtl/mips_defs.sv
// Shared MIPS definitions: opcodes, funct codes, control encodings and
// the internal ALU operation set. Control imports the same opcode constants.
package mips_defs;

    // Primary opcodes, IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes, IR[5:0]
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // ALUop classes driven by Control
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    // PC next-value sources
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_HOLD   = 2'b11;

    // ALU operand B sources
    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    // ALUop + funct -> concrete ALU operation; unknown funct falls back to add
    function automatic alu_op_e alu_decode(input logic [1:0] aluop, input logic [5:0] funct);
        alu_op_e res;
        res = ALU_ADD;
        case (aluop)
            ALUOP_SUB: res = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: res = ALU_ADD;
                    FUNCT_SUB: res = ALU_SUB;
                    FUNCT_AND: res = ALU_AND;
                    FUNCT_OR:  res = ALU_OR;
                    FUNCT_SLT: res = ALU_SLT;
                    default:   res = ALU_ADD;
                endcase
            end
            default: res = ALU_ADD;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/reg_file.sv
// 32-entry register file: two asynchronous read ports, one synchronous
// write port, asynchronous clear. Register 0 always reads as zero.
module reg_file #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       raddr1,
    input  logic [4:0]       raddr2,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2,
    input  logic             we,
    input  logic [4:0]       waddr,
    input  logic [WIDTH-1:0] wdata
);

    logic [WIDTH-1:0] regs [0:31];

    // Storage: cleared on reset, written at the edge; writes to $0 dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Read ports: same-cycle write is not forwarded, the old value is seen
    always_comb begin
        rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
        rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];
    end

endmodule

// File: rtl/mc_datapath.sv
// Multicycle MIPS datapath. Executes the per-cycle control word from the
// Control FSM, holds PC/IR/MDR/A/B/ALUOut, and drives one unified memory port.
module mc_datapath #(
    parameter int             WIDTH    = 32,
    parameter logic [WIDTH-1:0] PC_RESET = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       PCSrc,
    input  logic             ALUSrcA,
    input  logic [1:0]       ALUSrcB,
    input  logic             IorD,
    input  logic             MemtoReg,
    input  logic             IRWrite,
    input  logic             RegWrite,
    input  logic             MemWrite,
    input  logic             RegDst,
    input  logic             PCwritecond,
    input  logic             PCWrite,
    input  logic [1:0]       ALUop,
    output logic [5:0]       op,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_we,
    input  logic [WIDTH-1:0] mem_rdata
);

    import mips_defs::*;

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] ir;
    logic [WIDTH-1:0] mdr;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] alu_out;

    logic [WIDTH-1:0] rf_rdata1;
    logic [WIDTH-1:0] rf_rdata2;
    logic [4:0]       rf_waddr;
    logic [WIDTH-1:0] rf_wdata;

    logic [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    alu_op_e          alu_op;
    logic             zero;
    logic [WIDTH-1:0] pc_next;
    logic             pc_we;

    assign op        = ir[31:26];
    assign imm_sext  = {{(WIDTH-16){ir[15]}}, ir[15:0]};
    assign mem_addr  = IorD ? alu_out : pc;
    assign mem_wdata = b_reg;
    assign mem_we    = MemWrite;
    assign rf_waddr  = RegDst ? ir[15:11] : ir[20:16];
    assign rf_wdata  = MemtoReg ? mdr : alu_out;
    assign zero      = (alu_result == '0);
    // PCWrite alone is unconditional; the branch path needs a zero result
    assign pc_we     = PCWrite | (PCwritecond & zero);

    reg_file #(.WIDTH(WIDTH)) u_rf (
        .clk    (clk),
        .reset  (reset),
        .raddr1 (ir[25:21]),
        .raddr2 (ir[20:16]),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2),
        .we     (RegWrite),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata)
    );

    // ALU operand selection and operation decode
    always_comb begin
        alu_a  = ALUSrcA ? a_reg : pc;
        alu_b  = b_reg;
        alu_op = alu_decode(ALUop, ir[5:0]);
        case (ALUSrcB)
            SRCB_B:       alu_b = b_reg;
            SRCB_FOUR:    alu_b = WIDTH'(4);
            SRCB_IMM:     alu_b = imm_sext;
            SRCB_IMM_SH2: alu_b = {imm_sext[WIDTH-3:0], 2'b00};
            default:      alu_b = b_reg;
        endcase
    end

    // ALU: wrapping arithmetic, signed set-less-than
    always_comb begin
        alu_result = alu_a + alu_b;
        case (alu_op)
            ALU_ADD: alu_result = alu_a + alu_b;
            ALU_SUB: alu_result = alu_a - alu_b;
            ALU_AND: alu_result = alu_a & alu_b;
            ALU_OR:  alu_result = alu_a | alu_b;
            ALU_SLT: alu_result = {{(WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            default: alu_result = alu_a + alu_b;
        endcase
    end

    // PC next-value select; the jump target keeps the upper PC nibble
    always_comb begin
        pc_next = pc;
        case (PCSrc)
            PCSRC_ALU:    pc_next = alu_result;
            PCSRC_ALUOUT: pc_next = alu_out;
            PCSRC_JUMP:   pc_next = {pc[WIDTH-1:28], ir[25:0], 2'b00};
            PCSRC_HOLD:   pc_next = pc;
            default:      pc_next = pc;
        endcase
    end

    // PC register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= PC_RESET;
        end else if (pc_we) begin
            pc <= pc_next;
        end
    end

    // Instruction register, loaded only on fetch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir <= '0;
        end else if (IRWrite) begin
            ir <= mem_rdata;
        end
    end

    // Inter-stage registers, refreshed every cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mdr     <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            alu_out <= '0;
        end else begin
            mdr     <= mem_rdata;
            a_reg   <= rf_rdata1;
            b_reg   <= rf_rdata2;
            alu_out <= alu_result;
        end
    end

endmodule

// File: tb/tb_mc_datapath.sv
// Bench for mc_datapath: the bench plays the Control FSM, owns the unified
// memory, and keeps an instruction-level model of PC and register file.
module tb_mc_datapath;

    localparam logic [31:0] PC_RST = 32'h0000_0000;

    typedef struct packed {
        logic [1:0] pcsrc;
        logic       srca;
        logic [1:0] srcb;
        logic       iord;
        logic       memtoreg;
        logic       irwrite;
        logic       regwrite;
        logic       memwrite;
        logic       regdst;
        logic       pcwc;
        logic       pcw;
        logic [1:0] aluop;
    } ctrl_t;

    typedef struct packed {
        logic        chk_op;
        logic [5:0]  op;
        logic [31:0] addr;
        logic        we;
        logic        chk_wd;
        logic [31:0] wd;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0]  PCSrc;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic        IorD, MemtoReg, IRWrite, RegWrite, MemWrite, RegDst, PCwritecond, PCWrite;
    logic [1:0]  ALUop;
    logic [5:0]  op;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    mc_datapath #(.WIDTH(32), .PC_RESET(PC_RST)) dut (
        .clk(clk), .reset(reset), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .IorD(IorD), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .RegDst(RegDst), .PCwritecond(PCwritecond), .PCWrite(PCWrite),
        .ALUop(ALUop), .op(op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    // ---------------- memory: low region and 0x3000_0xxx region ----------------
    logic [31:0] mem_lo [0:255];
    logic [31:0] mem_hi [0:255];
    assign mem_rdata = (mem_addr[31:28] == 4'h3) ? mem_hi[mem_addr[9:2]] : mem_lo[mem_addr[9:2]];

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        return (a[31:28] == 4'h3) ? mem_hi[a[9:2]] : mem_lo[a[9:2]];
    endfunction

    // ---------------- model and scoreboard state ----------------
    logic [31:0] rf_m [0:31];
    logic [31:0] pc_m;
    logic [72:0] exp_q [$];
    int n_tests = 0;
    int n_fail  = 0;

    int          we_cnt;
    logic [31:0] obs_wa, obs_wd, obs_if_addr, obs_id_addr;
    logic [5:0]  obs_id_op;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic co, input logic [5:0] o, input logic [31:0] a,
                                input logic we, input logic cw, input logic [31:0] wd);
        exp_t e;
        e.chk_op = co; e.op = o; e.addr = a; e.we = we; e.chk_wd = cw; e.wd = wd;
        return e;
    endfunction

    // Compare process: every cycle with a pending expectation
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (e.chk_op) cmp("cyc_op", {26'd0, op}, {26'd0, e.op});
            cmp("cyc_addr", mem_addr, e.addr);
            cmp("cyc_we", {31'd0, mem_we}, {31'd0, e.we});
            if (e.chk_wd) cmp("cyc_wdata", mem_wdata, e.wd);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input ctrl_t c);
        PCSrc = c.pcsrc; ALUSrcA = c.srca; ALUSrcB = c.srcb; IorD = c.iord;
        MemtoReg = c.memtoreg; IRWrite = c.irwrite; RegWrite = c.regwrite;
        MemWrite = c.memwrite; RegDst = c.regdst; PCwritecond = c.pcwc;
        PCWrite = c.pcw; ALUop = c.aluop;
    endtask

    // One clock cycle: kind 0 = fetch, 1 = decode, 2 = later
    task automatic step(input ctrl_t c, input exp_t e, input int kind);
        logic        wr_pend;
        logic [31:0] wa, wd;
        wr_pend = 1'b0; wa = '0; wd = '0;
        drive(c);
        exp_q.push_back(e);
        @(negedge clk);
        if (kind == 0) obs_if_addr = mem_addr;
        if (kind == 1) begin obs_id_addr = mem_addr; obs_id_op = op; end
        if (mem_we) begin
            we_cnt++; wr_pend = 1'b1; wa = mem_addr; wd = mem_wdata;
            obs_wa = mem_addr; obs_wd = mem_wdata;
        end
        @(posedge clk);
        #1;
        if (wr_pend) begin
            if (wa[31:28] == 4'h3) mem_hi[wa[9:2]] = wd;
            else                   mem_lo[wa[9:2]] = wd;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive('0);
        for (int i = 0; i < 32; i++) rf_m[i] = '0;
        pc_m = PC_RST;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(1'b1, 6'd0, PC_RST, 1'b0, 1'b1, 32'd0));
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    task automatic load_prog(input logic [31:0] words [], input logic [31:0] base);
        for (int i = 0; i < words.size(); i++) mem_lo[base[9:2] + 8'(i)] = words[i];
    endtask

    // Execute the instruction at the model PC; abort_mem resets during an lw memory cycle
    task automatic exec_one(input bit abort_mem);
        logic [31:0] ins, pc4, imm, ea, a, b, r;
        logic [5:0]  opc, funct;
        logic [4:0]  rs, rt, rd;
        ctrl_t c;
        ins = rd_mem(pc_m);
        opc = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; funct = ins[5:0];
        imm = {{16{ins[15]}}, ins[15:0]};
        a = rf_m[rs]; b = rf_m[rt];
        pc4 = pc_m + 32'd4;
        ea  = a + imm;
        we_cnt = 0;

        c = '0; c.srcb = 2'b01; c.irwrite = 1'b1; c.pcw = 1'b1;
        step(c, mk(1'b0, 6'd0, pc_m, 1'b0, 1'b0, 32'd0), 0);
        c = '0; c.srcb = 2'b11;
        step(c, mk(1'b1, opc, pc4, 1'b0, 1'b0, 32'd0), 1);

        case (opc)
            6'b001000: begin // addi
                c = '0; c.srca = 1'b1; c.srcb = 2'b10;
                step(c, mk(1'b1, opc, pc4, 1'b0, 1'b1, b), 2);
                c = '0; c.regwrite = 1'b1;
                step(c, mk(1'b1, opc, pc4, 1'b0, 1'b1, b), 2);
                if (rt != 5'd0) rf_m[rt] = a + imm;
                pc_m = pc4;
            end
            6'b000000: begin
                if (funct == 6'b001000) begin // register jump: PC <= rs + rt
                    c = '0; c.srca = 1'b1; c.aluop = 2'b10; c.pcw = 1'b1;
                    step(c, mk(1'b1, opc, pc4, 1'b0, 1'b1, b), 2);
                    pc_m = a + b;
                end else begin
                    case (funct)
                        6'b100010: r = a - b;
                        6'b100100: r = a & b;
                        6'b100101: r = a | b;
                        6'b101010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        default:   r = a + b;
                    endcase
                    c = '0; c.srca = 1'b1; c.aluop = 2'b10;
                    step(c, mk(1'b1, opc, pc4, 1'b0, 1'b1, b), 2);
                    c = '0; c.regdst = 1'b1; c.regwrite = 1'b1;
                    step(c, mk(1'b1, opc, pc4, 1'b0, 1'b1, b), 2);
                    if (rd != 5'd0) rf_m[rd] = r;
                    pc_m = pc4;
                end
            end
            6'b101011: begin // sw
                c = '0; c.srca = 1'b1; c.srcb = 2'b10;
                step(c, mk(1'b1, opc, pc4, 1'b0, 1'b1, b), 2);
                c = '0; c.iord = 1'b1; c.memwrite = 1'b1;
                step(c, mk(1'b1, opc, ea, 1'b1, 1'b1, b), 2);
                pc_m = pc4;
            end
            6'b100011: begin // lw
                c = '0; c.srca = 1'b1; c.srcb = 2'b10;
                step(c, mk(1'b1, opc, pc4, 1'b0, 1'b1, b), 2);
                c = '0; c.iord = 1'b1;
                if (abort_mem) begin
                    drive(c);
                    exp_q.push_back(mk(1'b1, opc, ea, 1'b0, 1'b1, b));
                    @(negedge clk);
                    #1;
                    reset = 1'b1;
                    drive('0);
                    #1;
                    cmp("async_reset_op", {26'd0, op}, 32'd0);
                    cmp("async_reset_addr", mem_addr, PC_RST);
                    do_reset();
                end else begin
                    step(c, mk(1'b1, opc, ea, 1'b0, 1'b1, b), 2);
                    c = '0; c.regwrite = 1'b1; c.memtoreg = 1'b1;
                    step(c, mk(1'b1, opc, pc4, 1'b0, 1'b1, b), 2);
                    if (rt != 5'd0) rf_m[rt] = rd_mem(ea);
                    pc_m = pc4;
                end
            end
            6'b000100: begin // beq
                c = '0; c.srca = 1'b1; c.aluop = 2'b01; c.pcwc = 1'b1; c.pcsrc = 2'b01;
                step(c, mk(1'b1, opc, pc4, 1'b0, 1'b1, b), 2);
                pc_m = (a == b) ? pc4 + {imm[29:0], 2'b00} : pc4;
            end
            6'b000010: begin // j
                c = '0; c.pcw = 1'b1; c.pcsrc = 2'b10;
                step(c, mk(1'b1, opc, pc4, 1'b0, 1'b1, b), 2);
                pc_m = {pc4[31:28], ins[25:0], 2'b00};
            end
            default: begin
                n_tests++; n_fail++;
                $display("FAIL bench_decode: got opcode 0x%02h expected a supported opcode", opc);
            end
        endcase
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] prog [];

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin mem_lo[i] = '0; mem_hi[i] = '0; end
    endtask

    initial begin
        reset = 1'b1;
        drive('0);
        clear_mem();
        prog = '{32'h20080005, 32'h20090007, 32'h01095020, 32'h0128582A,
                 32'h11080003, 32'h00000000, 32'h00000000, 32'h00000000,
                 32'hAC0B0100, 32'h2009FFFF, 32'h0128582A, 32'hAC0A0008,
                 32'h8C0C0008, 32'h20000009, 32'hAC0B0104, 32'hAC0C0108,
                 32'hAC00010C, 32'h8C0E0080, 32'h01C00008};
        load_prog(prog, 32'h0);
        mem_lo[32] = 32'h3000_0000;          // data word at 0x80
        mem_hi[0]  = 32'h08000040;           // 0x30000000: j 0x40
        mem_hi[64] = 32'hAC080110;           // 0x30000100: sw $8,0x110($0)
        do_reset();

        exec_one(0);                         // addi $8,$0,5
        cmp("if_op_addi", {26'd0, obs_id_op}, 32'h0000_0008);
        cmp("if_pc_plus4", obs_id_addr, 32'h4);
        for (int i = 0; i < 4; i++) exec_one(0);   // addi $9; add; slt; beq taken
        exec_one(0);                         // sw $11,0x100
        cmp("beq_taken_pc", obs_if_addr, 32'h20);
        cmp("slt_false", obs_wd, 32'd0);
        exec_one(0); exec_one(0);            // addi $9,-1; slt
        exec_one(0);                         // sw $10,8($0)
        cmp("sw_we_cycles", 32'(we_cnt), 32'd1);
        cmp("sw_addr", obs_wa, 32'h8);
        cmp("sw_wdata_add", obs_wd, 32'd12);
        exec_one(0); exec_one(0);            // lw $12; addi $0,$0,9
        exec_one(0);
        cmp("slt_true", obs_wd, 32'd1);
        exec_one(0);
        cmp("lw_value", obs_wd, 32'd12);
        exec_one(0);
        cmp("r0_discard", obs_wd, 32'd0);
        exec_one(0); exec_one(0);            // lw $14; register jump
        exec_one(0);                         // j at 0x30000000
        cmp("jr_pc", obs_if_addr, 32'h3000_0000);
        exec_one(0);                         // sw $8 at 0x30000100
        cmp("j_pc", obs_if_addr, 32'h3000_0100);
        cmp("addi_r8", obs_wd, 32'd5);
        cmp("model_r10", rf_m[10], 32'd12);
        cmp("model_r11", rf_m[11], 32'd1);

        // Not-taken branch, then reset during an lw memory cycle
        clear_mem();
        prog[4] = 32'h11090003;              // beq $8,$9,+3
        prog[5] = 32'h8C0C0080;              // lw $12,0x80($0)
        load_prog(prog, 32'h0);
        mem_lo[32] = 32'h3000_0000;
        do_reset();
        for (int i = 0; i < 5; i++) exec_one(0);
        cmp("beq_not_taken_pc", pc_m, 32'h14);
        exec_one(1);
        cmp("beq_not_taken_fetch", obs_if_addr, 32'h14);
        mem_lo[0] = 32'hAC0C0120;            // sw $12,0x120($0)
        exec_one(0);
        cmp("restart_pc", obs_if_addr, PC_RST);
        cmp("abort_no_wb", obs_wd, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
